// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the shift-add multiplier control path:
// state encoding, strobe bundle, Moore output decode and iteration-counter width.
package mult_ctrl_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int CYC_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic load_regs;
    logic clr_acc;
    logic add_en;
    logic shift_en;
  } ctrl_t;

  // Smallest width able to hold 0..n-1; never below one bit.
  function automatic int iter_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE:    c.ready = 1'b1;
      INIT: begin
        c.busy      = 1'b1;
        c.load_regs = 1'b1;
        c.clr_acc   = 1'b1;
      end
      TEST:    c.busy = 1'b1;
      ADD: begin
        c.busy   = 1'b1;
        c.add_en = 1'b1;
      end
      SHIFT: begin
        c.busy     = 1'b1;
        c.shift_en = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c.ready = 1'b1;
    endcase
    return c;
  endfunction

  localparam ctrl_t CTRL_IDLE = decode_ctrl(IDLE);

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/Done handshake and datapath strobe bundle for mult_seq_ctrl.
// The Cycles signal exists only when MULT_CYCLE_CNT_EN is defined.
interface mult_seq_ctrl_if
`ifdef MULT_CYCLE_CNT_EN
  #(parameter int CYC_W = 8)
`endif
  ;

  logic Start;
  logic Abort;
  logic Q0;
  logic Ready;
  logic Busy;
  logic Done;
  logic LoadRegs;
  logic ClrAcc;
  logic AddEn;
  logic ShiftEn;
`ifdef MULT_CYCLE_CNT_EN
  logic [CYC_W-1:0] Cycles;

  modport master (
    output Start, Abort, Q0,
    input  Ready, Busy, Done, LoadRegs, ClrAcc, AddEn, ShiftEn, Cycles
  );

  modport slave (
    input  Start, Abort, Q0,
    output Ready, Busy, Done, LoadRegs, ClrAcc, AddEn, ShiftEn, Cycles
  );
`else
  modport master (
    output Start, Abort, Q0,
    input  Ready, Busy, Done, LoadRegs, ClrAcc, AddEn, ShiftEn
  );

  modport slave (
    input  Start, Abort, Q0,
    output Ready, Busy, Done, LoadRegs, ClrAcc, AddEn, ShiftEn
  );
`endif

endinterface

// File: rtl/mult_seq_ctrl_iter_cnt.sv
// Iteration counter for the multiplier FSM: synchronous clear/enable,
// asynchronous Reset, Last flags the final test/shift iteration.
module mult_iter_cnt
  import mult_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clr,
  input  logic En,
  output logic Last
);

  localparam int ITER_W = iter_w(N);

  logic [ITER_W-1:0] count_q;
  logic [ITER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (Clr) begin
      count_d = '0;
    end else if (En) begin
      count_d = count_q + ITER_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Last = (count_q == ITER_W'(N - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the shift-add multiplier: load, clear, per-bit test/add/shift, done.
// Define MULT_CYCLE_CNT_EN to add the saturating Cycles output.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
`ifdef MULT_CYCLE_CNT_EN
  ,
  parameter int CYC_W = CYC_W_DEFAULT
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_seq_ctrl_if.slave  bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;

  logic iter_clr_s;
  logic iter_en_s;
  logic iter_last_s;
  logic in_flight_s;

  assign iter_clr_s  = (state_q == INIT);
  assign iter_en_s   = (state_q == SHIFT);
  assign in_flight_s = (state_q == INIT) || (state_q == TEST) ||
                       (state_q == ADD)  || (state_q == SHIFT);

  mult_iter_cnt #(
    .N (N)
  ) u_iter_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (iter_clr_s),
    .En    (iter_en_s),
    .Last  (iter_last_s)
  );

  // Abort outranks Q0 and the last-iteration test in every in-flight state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = INIT;
        else           state_d = IDLE;
      end
      INIT: begin
        if (bus.Abort) state_d = IDLE;
        else           state_d = TEST;
      end
      TEST: begin
        if (bus.Abort)   state_d = IDLE;
        else if (bus.Q0) state_d = ADD;
        else             state_d = SHIFT;
      end
      ADD: begin
        if (bus.Abort) state_d = IDLE;
        else           state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.Abort)        state_d = IDLE;
        else if (iter_last_s) state_d = DONE;
        else                  state_d = TEST;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  // Strobes are flopped alongside the state so they always equal the decode of state_q.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.Ready    = ctrl_q.ready;
  assign bus.Busy     = ctrl_q.busy;
  assign bus.Done     = ctrl_q.done;
  assign bus.LoadRegs = ctrl_q.load_regs;
  assign bus.ClrAcc   = ctrl_q.clr_acc;
  assign bus.AddEn    = ctrl_q.add_en;
  assign bus.ShiftEn  = ctrl_q.shift_en;

`ifdef MULT_CYCLE_CNT_EN
  logic [CYC_W-1:0] cycles_q;
  logic [CYC_W-1:0] cycles_d;

  // INIT restarts the count at 1; the value reads 25 in DONE for N=8, multiplier 0xFF.
  always_comb begin
    cycles_d = cycles_q;
    if (in_flight_s && bus.Abort) begin
      cycles_d = cycles_q;
    end else if (state_q == INIT) begin
      cycles_d = CYC_W'(1);
    end else if (in_flight_s && (cycles_q != {CYC_W{1'b1}})) begin
      cycles_d = cycles_q + CYC_W'(1);
    end else begin
      cycles_d = cycles_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign bus.Cycles = cycles_q;
`else
  logic unused_in_flight_s;
  assign unused_in_flight_s = in_flight_s;
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with an attached shift-add datapath model
// and expectations derived from plain arithmetic (a*b, popcount, cycle formula).
module tb_mult_seq_ctrl;

  localparam int N = 8;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  mult_seq_ctrl_if bus_if ();

  mult_seq_ctrl #(
    .N (N)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  logic [7:0] op_a  = 8'd0;
  logic [7:0] op_b  = 8'd0;
  logic [7:0] a_reg = 8'd0;
  logic [7:0] m_reg = 8'd0;
  logic [8:0] acc   = 9'd0;

  // Behavioural datapath driven by the controller's strobes.
  always @(posedge Clk) begin
    if (bus_if.LoadRegs) begin
      a_reg <= op_a;
      m_reg <= op_b;
    end
    if (bus_if.ClrAcc) acc <= 9'd0;
    if (bus_if.AddEn) acc <= acc + {1'b0, a_reg};
    if (bus_if.ShiftEn) {acc, m_reg} <= {acc, m_reg} >> 1;
  end

  assign bus_if.Q0 = m_reg[0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus_if.Ready, bus_if.Busy, bus_if.Done, bus_if.LoadRegs,
            bus_if.ClrAcc, bus_if.AddEn, bus_if.ShiftEn};
  endfunction

  // Entered and left at a falling edge while the controller sits in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int abort_test,
                        input bit reset_on_add, input bit hold_start, input bit start_with_abort);
    int add_cnt, shift_cnt, done_cnt, done_k, test_cnt;
    bit fin, abort_pending, did_reset;
    logic [15:0] prod, exp_prod;
    add_cnt = 0; shift_cnt = 0; done_cnt = 0; done_k = -1; test_cnt = 0;
    fin = 1'b0; abort_pending = 1'b0; did_reset = 1'b0; prod = 16'd0;
    exp_prod = 16'(a) * 16'(b);
    op_a = a;
    op_b = b;
    bus_if.Start = 1'b1;
    bus_if.Abort = start_with_abort;
    @(posedge Clk);
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        check_eq("init_strobes", {25'd0, outs()}, {25'd0, 7'b0101100});
        bus_if.Abort = 1'b0;
      end
      if (done_k > 0) begin
        check_eq("idle_after_done", {25'd0, outs()}, {25'd0, 7'b1000000});
        fin = 1'b1;
      end else if (abort_pending) begin
        check_eq("abort_to_idle", {25'd0, outs()}, {25'd0, 7'b1000000});
        bus_if.Abort = 1'b0;
        fin = 1'b1;
      end else if (reset_on_add && bus_if.AddEn) begin
        bus_if.Start = 1'b0;
        Reset = 1'b1;
        #1;
        check_eq("reset_mid_add", {25'd0, outs()}, {25'd0, 7'b1000000});
        @(negedge Clk);
        Reset = 1'b0;
        did_reset = 1'b1;
        fin = 1'b1;
      end else begin
        add_cnt   += int'(bus_if.AddEn);
        shift_cnt += int'(bus_if.ShiftEn);
        if (bus_if.Busy && !bus_if.LoadRegs && !bus_if.AddEn && !bus_if.ShiftEn)
          test_cnt++;
        if (bus_if.Done) begin
          done_cnt++;
          done_k = k;
          prod = {acc[7:0], m_reg};
          bus_if.Start = hold_start;
        end else if (abort_test > 0 && test_cnt == abort_test && bus_if.Busy &&
                     !bus_if.LoadRegs && !bus_if.AddEn && !bus_if.ShiftEn) begin
          bus_if.Abort = 1'b1;
          bus_if.Start = 1'b0;
          abort_pending = 1'b1;
        end else begin
          bus_if.Start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
    end
    if (!fin) check_eq("timeout", 32'd0, 32'd1);
    if (abort_pending || did_reset) begin
      check_eq("no_done_after_cancel", done_cnt, 32'd0);
    end else begin
      check_eq("done_cycle", done_k, 2 + 2 * N + $countones(b));
      check_eq("add_count", add_cnt, $countones(b));
      check_eq("shift_count", shift_cnt, N);
      check_eq("done_pulses", done_cnt, 32'd1);
      check_eq("product", {16'd0, prod}, {16'd0, exp_prod});
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus_if.Start = 1'b0;
    bus_if.Abort = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset_outputs", {25'd0, outs()}, {25'd0, 7'b1000000});
    @(negedge Clk);
    Reset = 1'b0;

    bus_if.Abort = 1'b1;
    @(negedge Clk);
    check_eq("abort_ignored_idle", {25'd0, outs()}, {25'd0, 7'b1000000});
    bus_if.Abort = 1'b0;

    run_op(8'd13, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    run_op(8'($urandom), 8'h00, 0, 1'b0, 1'b0, 1'b0);
    run_op(8'($urandom), 8'hFF, 0, 1'b0, 1'b0, 1'b0);
    run_op(8'($urandom), 8'hFF, 3, 1'b0, 1'b0, 1'b0);
    run_op(8'($urandom), 8'hFF, 0, 1'b0, 1'b0, 1'b0);
    run_op(8'($urandom), 8'h0F, 0, 1'b1, 1'b0, 1'b0);
    run_op(8'd7, 8'h55, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_op(8'($urandom), 8'($urandom), 0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      run_op(8'($urandom), 8'($urandom), 0, 1'b0, 1'b0, 1'b0);
    end
    bus_if.Start = 1'b0;
    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
